// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS-lite main FSM (master) and its datapath (slave).
// Carries the opcode/memory handshake in and every datapath enable, the ALU-op pair and debug state out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       aluop1;
  logic       aluop0;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, pcsource, aluop1, aluop0,
           illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, pcsource, aluop1, aluop0,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-lite datapath: fetch/decode/execute/memory/writeback sequencing.
// Define MULTICYCLE_ADDI_EN to accept addi (opcode 001000) through the ADDI_EX/ADDI_WB states.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  state_t state_q;
  logic   illegal_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:    if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_RTYPE_EX;
            OP_BEQ:       state_q <= S_BEQ_EX;
            OP_J:         state_q <= S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI:      state_q <= S_ADDI_EX;
`endif
            default: begin
              state_q   <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          if (bus.opcode == OP_LW)      state_q <= S_MEMREAD;
          else if (bus.opcode == OP_SW) state_q <= S_MEMWRITE;
          else                          state_q <= S_FETCH;
        end
        S_MEMREAD:  if (bus.mem_ready) state_q <= S_MEMWB;
        S_MEMWRITE: if (bus.mem_ready) state_q <= S_FETCH;
        S_RTYPE_EX: state_q <= S_RTYPE_WB;
`ifdef MULTICYCLE_ADDI_EN
        S_ADDI_EX:  state_q <= S_ADDI_WB;
`endif
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case, so no latch is inferred for unlisted states.
  always_comb begin
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.irwrite     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.pcsource    = 2'b00;
    bus.aluop1      = 1'b0;
    bus.aluop0      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          // IR load and PC+4 only commit in the cycle the instruction word arrives.
          bus.memread = 1'b1;
          bus.alusrcb = 2'b01;
          bus.irwrite = bus.mem_ready;
          bus.pcwrite = bus.mem_ready;
        end
        S_DECODE:   bus.alusrcb = 2'b11;
        S_MEMADR: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        S_MEMREAD: begin
          bus.memread = 1'b1;
          bus.iord    = 1'b1;
        end
        S_MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
        end
        S_MEMWRITE: begin
          bus.memwrite = 1'b1;
          bus.iord     = 1'b1;
        end
        S_RTYPE_EX: begin
          bus.alusrca = 1'b1;
          bus.aluop1  = 1'b1;
        end
        S_RTYPE_WB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
        end
        S_BEQ_EX: begin
          bus.alusrca     = 1'b1;
          bus.aluop0      = 1'b1;
          bus.pcwritecond = 1'b1;
          bus.pcsource    = 2'b01;
        end
        S_JUMP: begin
          bus.pcwrite  = 1'b1;
          bus.pcsource = 2'b10;
        end
`ifdef MULTICYCLE_ADDI_EN
        S_ADDI_EX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        S_ADDI_WB:  bus.regwrite = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.illegal_op = illegal_q;
  assign bus.state      = state_q;

endmodule
